// File: rtl/axi_lite_read_data_slave.sv
// AXI4-Lite read path: accepts one AR beat, decodes it, reads a fixed-latency
// register bank and holds the R beat until the master accepts it.
module axi_lite_read_data_slave #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned SECURE_ONLY  = 0
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  input  logic [ADDR_WIDTH-1:0]       ARADDR,
  input  logic [2:0]                  ARPROT,
  output logic                        RVALID,
  input  logic                        RREADY,
  output logic [DATA_WIDTH-1:0]       RDATA,
  output logic [1:0]                  RRESP,
  output logic                        reg_rd_en,
  output logic [$clog2(NUM_REGS)-1:0] reg_rd_addr,
  input  logic [DATA_WIDTH-1:0]       reg_rd_data
);

  localparam int unsigned WORD_BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W      = $clog2(WORD_BYTES);
  localparam int unsigned IDX_W      = $clog2(NUM_REGS);
  localparam int unsigned CNT_W      = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

  // DECODE is the cycle spent classifying the captured address.
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_READ, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    nonsec_q, nonsec_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    arready_d, rvalid_d, rd_en_d;
  logic [DATA_WIDTH-1:0]   rdata_d;
  logic [1:0]              rresp_d;
  logic [IDX_W-1:0]        rd_addr_d;
  logic                    misaligned, out_of_range, prot_denied;
  logic                    unused_prot;

  assign unused_prot  = ^{ARPROT[2], ARPROT[0]};

  assign misaligned   = |addr_q[OFF_W-1:0];
  assign out_of_range = |addr_q[ADDR_WIDTH-1:OFF_W+IDX_W];
  assign prot_denied  = (SECURE_ONLY != 0) && nonsec_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    nonsec_d  = nonsec_q;
    cnt_d     = cnt_q;
    arready_d = ARREADY;
    rvalid_d  = RVALID;
    rdata_d   = RDATA;
    rresp_d   = RRESP;
    rd_en_d   = 1'b0;
    rd_addr_d = reg_rd_addr;

    case (state_q)
      S_IDLE: begin
        arready_d = 1'b1;
        if (ARVALID && ARREADY) begin
          addr_d    = ARADDR;
          nonsec_d  = ARPROT[1];
          arready_d = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (misaligned || out_of_range || prot_denied) begin
          rvalid_d = 1'b1;
          rdata_d  = '0;
          rresp_d  = misaligned   ? RESP_SLVERR :
                     out_of_range ? RESP_DECERR : RESP_SLVERR;
          state_d  = S_RESP;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = addr_q[OFF_W +: IDX_W];
          cnt_d     = '0;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d  = reg_rd_data;
          rresp_d  = RESP_OKAY;
          rvalid_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (RVALID && RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      nonsec_q    <= 1'b0;
      cnt_q       <= '0;
      ARREADY     <= 1'b0;
      RVALID      <= 1'b0;
      RDATA       <= '0;
      RRESP       <= RESP_OKAY;
      reg_rd_en   <= 1'b0;
      reg_rd_addr <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      nonsec_q    <= nonsec_d;
      cnt_q       <= cnt_d;
      ARREADY     <= arready_d;
      RVALID      <= rvalid_d;
      RDATA       <= rdata_d;
      RRESP       <= rresp_d;
      reg_rd_en   <= rd_en_d;
      reg_rd_addr <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_read_data_slave.sv
// Directed bench: dut_a (latency 1, non-secure allowed), dut_b (latency 4, secure only).
module tb_axi_lite_read_data_slave;

  logic        clk, rst_n;
  int          npass, ntotal;
  logic [31:0] cyc;

  logic        a_arvalid, a_arready, a_rvalid, a_rready, a_rd_en;
  logic [31:0] a_araddr, a_rdata, a_rd_data;
  logic [2:0]  a_arprot;
  logic [1:0]  a_rresp;
  logic [3:0]  a_rd_addr;

  logic        b_arvalid, b_arready, b_rvalid, b_rready, b_rd_en;
  logic [31:0] b_araddr, b_rdata, b_rd_data;
  logic [2:0]  b_arprot;
  logic [1:0]  b_rresp;
  logic [3:0]  b_rd_addr;

  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [2:0]  b_en_p;
  logic [3:0]  b_addr_p [3];

  axi_lite_read_data_slave #(.READ_LATENCY(1), .SECURE_ONLY(0)) dut_a (
    .ACLK(clk), .ARESETn(rst_n), .ARVALID(a_arvalid), .ARREADY(a_arready),
    .ARADDR(a_araddr), .ARPROT(a_arprot), .RVALID(a_rvalid), .RREADY(a_rready),
    .RDATA(a_rdata), .RRESP(a_rresp), .reg_rd_en(a_rd_en),
    .reg_rd_addr(a_rd_addr), .reg_rd_data(a_rd_data));

  axi_lite_read_data_slave #(.READ_LATENCY(4), .SECURE_ONLY(1)) dut_b (
    .ACLK(clk), .ARESETn(rst_n), .ARVALID(b_arvalid), .ARREADY(b_arready),
    .ARADDR(b_araddr), .ARPROT(b_arprot), .RVALID(b_rvalid), .RREADY(b_rready),
    .RDATA(b_rdata), .RRESP(b_rresp), .reg_rd_en(b_rd_en),
    .reg_rd_addr(b_rd_addr), .reg_rd_data(b_rd_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank models: valid data only in the cycle before the capture edge, junk otherwise.
  always @(posedge clk) begin
    cyc       <= cyc + 32'd1;
    b_en_p    <= {b_en_p[1:0], b_rd_en};
    b_addr_p[2] <= b_addr_p[1];
    b_addr_p[1] <= b_addr_p[0];
    b_addr_p[0] <= b_rd_addr;
  end
  assign a_rd_data = a_rd_en   ? mem_a[a_rd_addr]   : (32'hBAD0_0000 | cyc);
  assign b_rd_data = b_en_p[2] ? mem_b[b_addr_p[2]] : (32'hBAD1_0000 | cyc);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic a_ar(input logic [31:0] addr);
    a_araddr  = addr;
    a_arvalid = 1'b1;
    tick();
    a_arvalid = 1'b0;
  endtask

  initial begin
    npass = 0; ntotal = 0; cyc = '0;
    b_en_p = '0;
    for (int i = 0; i < 3; i++) b_addr_p[i] = '0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 32'h0A00_0000 + 32'(i);
      mem_b[i] = 32'h0B00_0000 + 32'(i);
    end
    mem_a[0] = 32'h1111_1111; mem_a[1] = 32'hCAFE_F00D; mem_a[2] = 32'hDEAD_BEEF;
    mem_b[15] = 32'h1234_5678;
    rst_n = 1'b0;
    a_arvalid = 0; a_araddr = '0; a_arprot = '0; a_rready = 0;
    b_arvalid = 0; b_araddr = '0; b_arprot = '0; b_rready = 0;

    // Reset values
    #12;
    chk("rst_arready", a_arready, 0);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_rresp", a_rresp, 0);
    chk("rst_rd_en", a_rd_en, 0);
    chk("rst_rd_addr", a_rd_addr, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("arready_after_rst", a_arready, 1);
    chk("b_arready_after_rst", b_arready, 1);

    // OK read at 0x8, latency 1
    a_rready = 1'b1;
    a_ar(32'h8);
    chk("ok_arready_low_e0", a_arready, 0);
    tick();
    chk("ok_rd_en_e1", a_rd_en, 1);
    chk("ok_rd_addr_e1", a_rd_addr, 2);
    chk("ok_rvalid_e1", a_rvalid, 0);
    tick();
    chk("ok_rd_en_e2", a_rd_en, 0);
    chk("ok_rvalid_e2", a_rvalid, 1);
    chk("ok_rdata_e2", a_rdata, 32'hDEAD_BEEF);
    chk("ok_rresp_e2", a_rresp, 0);
    tick();
    chk("ok_rvalid_e3", a_rvalid, 0);
    chk("ok_arready_e3", a_arready, 1);

    // Misaligned -> SLVERR
    a_ar(32'h6);
    chk("mis_rd_en_e0", a_rd_en, 0);
    tick();
    chk("mis_rvalid_e1", a_rvalid, 1);
    chk("mis_rresp", a_rresp, 2'b10);
    chk("mis_rdata", a_rdata, 0);
    chk("mis_rd_en_e1", a_rd_en, 0);
    tick();
    chk("mis_arready", a_arready, 1);

    // Out of range -> DECERR
    a_ar(32'h40);
    tick();
    chk("oor_rvalid", a_rvalid, 1);
    chk("oor_rresp", a_rresp, 2'b11);
    chk("oor_rd_en", a_rd_en, 0);
    tick();
    chk("oor_arready", a_arready, 1);

    // Backpressure with a second AR held
    a_rready = 1'b0;
    a_ar(32'h4);
    a_araddr = 32'h0; a_arvalid = 1'b1;
    tick(); tick();
    chk("bp_rvalid_e2", a_rvalid, 1);
    chk("bp_rdata_e2", a_rdata, 32'hCAFE_F00D);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_rvalid_hold", a_rvalid, 1);
      chk("bp_rdata_hold", a_rdata, 32'hCAFE_F00D);
      chk("bp_rresp_hold", a_rresp, 0);
      chk("bp_arready_hold", a_arready, 0);
    end
    a_rready = 1'b1;
    tick();
    chk("bp_r_hs_rvalid", a_rvalid, 0);
    chk("bp_r_hs_arready", a_arready, 1);
    tick();
    a_arvalid = 1'b0;
    chk("bp_second_ar_taken", a_arready, 0);
    tick();
    chk("bp2_rd_addr", a_rd_addr, 0);
    tick();
    chk("bp2_rdata", a_rdata, 32'h1111_1111);
    tick();

    // Back-to-back reads 0x0, 0x4, 0x8 with ARVALID/RREADY held
    a_araddr = 32'h0; a_arvalid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      a_araddr = 32'((i + 1) * 4);
      tick(); tick();
      chk("b2b_rvalid", a_rvalid, 1);
      chk("b2b_rdata", a_rdata, mem_a[i]);
      tick();
      chk("b2b_r_hs_rvalid", a_rvalid, 0);
      chk("b2b_r_hs_arready", a_arready, 1);
      if (i == 2) a_arvalid = 1'b0;
      else begin
        tick();
        chk("b2b_next_ar", a_arready, 0);
      end
    end

    // Reset during READ
    a_ar(32'h0);
    tick();
    chk("mr_in_read", a_rd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_read_rvalid", a_rvalid, 0);
    chk("mr_read_arready", a_arready, 0);
    chk("mr_read_rd_en", a_rd_en, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("mr_read_arready_back", a_arready, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_read_no_r", a_rvalid, 0);
    end

    // Reset during RESP
    a_rready = 1'b0;
    a_ar(32'h8);
    tick(); tick();
    chk("mr_in_resp", a_rvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_resp_rvalid", a_rvalid, 0);
    chk("mr_resp_arready", a_arready, 0);
    chk("mr_resp_rdata", a_rdata, 0);
    @(negedge clk) rst_n = 1'b1;
    a_rready = 1'b1;
    tick();
    chk("mr_resp_arready_back", a_arready, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_resp_no_r", a_rvalid, 0);
    end

    // dut_b: non-secure access denied
    b_rready = 1'b1;
    b_araddr = 32'h0; b_arprot = 3'b010; b_arvalid = 1'b1;
    tick();
    b_arvalid = 1'b0;
    tick();
    chk("sec_rvalid", b_rvalid, 1);
    chk("sec_rresp", b_rresp, 2'b10);
    chk("sec_rdata", b_rdata, 0);
    tick();
    chk("sec_arready", b_arready, 1);

    // dut_b: latency 4 read of word 15
    b_rready = 1'b0;
    b_araddr = 32'h3C; b_arprot = 3'b000; b_arvalid = 1'b1;
    tick();
    b_arvalid = 1'b0;
    tick();
    chk("lat_rd_en", b_rd_en, 1);
    chk("lat_rd_addr", b_rd_addr, 15);
    tick(); tick(); tick();
    chk("lat_rvalid_e4", b_rvalid, 0);
    tick();
    chk("lat_rvalid_e5", b_rvalid, 1);
    chk("lat_rdata", b_rdata, 32'h1234_5678);
    chk("lat_rresp", b_rresp, 0);
    tick();
    chk("lat_rdata_held", b_rdata, 32'h1234_5678);
    b_rready = 1'b1;
    tick();
    chk("lat_r_hs", b_rvalid, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
